// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer sharing one byte-serial memory controller
// between instruction fetch and the load/store buffer.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_clear,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,

  input  logic              lsb_req,
  input  logic              lsb_is_write,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [DATA_W-1:0] lsb_wdata,
  input  logic [2:0]        lsb_type,
  output logic              lsb_done,
  output logic [DATA_W-1:0] lsb_data,

  output logic              mc_new_task,
  output logic              mc_is_write,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [DATA_W-1:0] mc_data_in,
  output logic [2:0]        mc_work_type,
  input  logic [DATA_W-1:0] mc_data_out,
  input  logic              mc_ready,
  input  logic              mc_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
  typedef enum logic {OWN_IF, OWN_LSB} owner_t;

  state_t state, state_nx;
  owner_t last_owner;

  logic              grant;
  logic              pick_lsb;
  logic              rd_complete;
  logic              wr_complete;
  logic [DATA_W-1:0] ld_ext;

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else if (rdy_in) begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (grant) state_nx = ISSUE;
      ISSUE: state_nx = (rob_clear && !mc_is_write) ? DRAIN : WAIT;
      WAIT: begin
        if (!mc_is_write && rob_clear)     state_nx = DRAIN;
        else if (rd_complete || wr_complete) state_nx = IDLE;
      end
      DRAIN: if (!mc_busy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant is held off while a done pulse is out, so the finishing requester
  // has dropped its level before IDLE samples the requests again.
  always_comb begin
    pick_lsb    = lsb_req && (!if_req || last_owner == OWN_IF);
    grant       = (state == IDLE) && !rob_clear && !if_done && !lsb_done &&
                  (if_req || lsb_req);
    rd_complete = (state == WAIT) && !mc_is_write && mc_ready && !rob_clear;
    wr_complete = (state == WAIT) && mc_is_write && !mc_busy;
    mc_new_task = (state == ISSUE) && rdy_in;
  end

  always_comb begin
    ld_ext = mc_data_out;
    unique case (mc_work_type[1:0])
      2'b00:   ld_ext = {{(DATA_W-8){~mc_work_type[2] & mc_data_out[7]}}, mc_data_out[7:0]};
      2'b01:   ld_ext = {{(DATA_W-16){~mc_work_type[2] & mc_data_out[15]}}, mc_data_out[15:0]};
      default: ld_ext = mc_data_out;
    endcase
  end

  // Task fields, result registers and done pulses
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_owner   <= OWN_IF;
      if_done      <= 1'b0;
      lsb_done     <= 1'b0;
      if_data      <= '0;
      lsb_data     <= '0;
      mc_is_write  <= 1'b0;
      mc_addr      <= '0;
      mc_data_in   <= '0;
      mc_work_type <= '0;
    end else if (rdy_in) begin
      if_done  <= rd_complete && (last_owner == OWN_IF);
      lsb_done <= wr_complete || (rd_complete && (last_owner == OWN_LSB));
      if (grant) begin
        if (pick_lsb) begin
          last_owner   <= OWN_LSB;
          mc_is_write  <= lsb_is_write;
          mc_addr      <= lsb_addr;
          mc_data_in   <= lsb_wdata;
          mc_work_type <= lsb_type;
        end else begin
          last_owner   <= OWN_IF;
          mc_is_write  <= 1'b0;
          mc_addr      <= if_addr;
          mc_data_in   <= '0;
          mc_work_type <= 3'b010;
        end
      end
      if (rd_complete) begin
        if (last_owner == OWN_IF) if_data  <= mc_data_out;
        else                      lsb_data <= ld_ext;
      end
    end
  end

endmodule
